// File: rtl/acc_pkg.sv
// Shared constants for the prescaled accumulator: direction codes and default geometry.
package acc_pkg;

    localparam logic ACC_UP   = 1'b0;
    localparam logic ACC_DOWN = 1'b1;

    localparam int ACC_WIDTH       = 24;
    localparam int ACC_DIV_WIDTH   = 26;
    localparam int ACC_DEFAULT_DIV = 12;

endpackage : acc_pkg

// File: rtl/tick_prescaler.sv
// Programmable prescaler: emits a tick event every div_active+1 enabled cycles.
// A new divisor is adopted only when the counter wraps; load clears the counter.
module tick_prescaler #(
    parameter int DIV_WIDTH   = acc_pkg::ACC_DIV_WIDTH,
    parameter int DEFAULT_DIV = acc_pkg::ACC_DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    output logic                 tick_event,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_r;
    logic [DIV_WIDTH-1:0] div_active_r;
    logic                 tick_r;
    logic                 wrap_s;

    // Load suppresses the event so that a coincident tick never updates the accumulator.
    assign wrap_s     = en && (count_r == div_active_r);
    assign tick_event = wrap_s && !load;
    assign tick       = tick_r;

    // Prescaler counter, divisor shadow and registered tick pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r      <= {DIV_WIDTH{1'b0}};
            div_active_r <= DIV_WIDTH'(DEFAULT_DIV);
            tick_r       <= 1'b0;
        end else begin
            tick_r <= tick_event;
            if (load) begin
                count_r <= {DIV_WIDTH{1'b0}};
            end else if (wrap_s) begin
                count_r      <= {DIV_WIDTH{1'b0}};
                div_active_r <= div;
            end else if (en) begin
                count_r <= count_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule : tick_prescaler

// File: rtl/prescaled_accumulator.sv
// Prescaled up/down accumulator with sticky overflow and a one-entry valid/ready sample register.
// Build option: define ACC_SAT_EN for saturating arithmetic (default is modulo wrap-around).
module prescaled_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH       = ACC_WIDTH,
    parameter int DIV_WIDTH   = ACC_DIV_WIDTH,
    parameter int DEFAULT_DIV = ACC_DEFAULT_DIV
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 En,
    input  logic [DIV_WIDTH-1:0] Div,
    input  logic [WIDTH-1:0]     Step,
    input  logic                 Dir,
    input  logic                 Load,
    input  logic [WIDTH-1:0]     Load_Value,
    input  logic                 Clr_Ovf,
    output logic [WIDTH-1:0]     Result,
    output logic                 Tick,
    output logic                 Overflow,
    output logic                 Sample_Valid,
    input  logic                 Sample_Ready,
    output logic [WIDTH-1:0]     Sample_Data,
    output logic                 Sample_Lost
);

    logic             tick_event_s;
    logic [WIDTH:0]   wide_s;
    logic             carry_s;
    logic [WIDTH-1:0] stepped_s;

    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             sample_valid_r;
    logic [WIDTH-1:0] sample_data_r;
    logic             sample_lost_r;

    tick_prescaler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk        (CLK),
        .rst        (RST),
        .en         (En),
        .div        (Div),
        .load       (Load),
        .tick_event (tick_event_s),
        .tick       (Tick)
    );

    // Next accumulator value; the extra top bit is carry (up) or borrow (down).
    always_comb begin
        wide_s    = {(WIDTH+1){1'b0}};
        stepped_s = {WIDTH{1'b0}};
        if (Dir == ACC_UP) begin
            wide_s = {1'b0, result_r} + {1'b0, Step};
        end else begin
            wide_s = {1'b0, result_r} - {1'b0, Step};
        end
        carry_s = wide_s[WIDTH];
`ifdef ACC_SAT_EN
        if (carry_s) begin
            stepped_s = (Dir == ACC_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end else begin
            stepped_s = wide_s[WIDTH-1:0];
        end
`else
        stepped_s = wide_s[WIDTH-1:0];
`endif
    end

    // Accumulator register: load wins over a step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_r <= {WIDTH{1'b0}};
        end else if (Load) begin
            result_r <= Load_Value;
        end else if (tick_event_s) begin
            result_r <= stepped_s;
        end else begin
            result_r <= result_r;
        end
    end

    // Sticky overflow: a new carry/borrow beats a coincident clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_r <= 1'b0;
        end else if (tick_event_s && carry_s) begin
            overflow_r <= 1'b1;
        end else if (Clr_Ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Sample register: capture when empty or draining this cycle, otherwise report the loss.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sample_valid_r <= 1'b0;
            sample_data_r  <= {WIDTH{1'b0}};
            sample_lost_r  <= 1'b0;
        end else begin
            sample_lost_r <= 1'b0;
            if (tick_event_s) begin
                if (!sample_valid_r || Sample_Ready) begin
                    sample_valid_r <= 1'b1;
                    sample_data_r  <= stepped_s;
                end else begin
                    sample_lost_r <= 1'b1;
                end
            end else if (sample_valid_r && Sample_Ready) begin
                sample_valid_r <= 1'b0;
            end else begin
                sample_valid_r <= sample_valid_r;
            end
        end
    end

    assign Result       = result_r;
    assign Overflow     = overflow_r;
    assign Sample_Valid = sample_valid_r;
    assign Sample_Data  = sample_data_r;
    assign Sample_Lost  = sample_lost_r;

endmodule : prescaled_accumulator

// File: tb/tb_prescaled_accumulator.sv
// Directed self-checking bench for prescaled_accumulator; expectations follow ACC_SAT_EN when defined.
module tb_prescaled_accumulator;

    localparam int WIDTH     = 24;
    localparam int DIV_WIDTH = 26;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 En = 1'b0;
    logic [DIV_WIDTH-1:0] Div = 26'd12;
    logic [WIDTH-1:0]     Step = 24'd1;
    logic                 Dir = 1'b0;
    logic                 Load = 1'b0;
    logic [WIDTH-1:0]     Load_Value = 24'd0;
    logic                 Clr_Ovf = 1'b0;
    logic [WIDTH-1:0]     Result;
    logic                 Tick;
    logic                 Overflow;
    logic                 Sample_Valid;
    logic                 Sample_Ready = 1'b1;
    logic [WIDTH-1:0]     Sample_Data;
    logic                 Sample_Lost;

    int checks = 0;
    int errors = 0;

    prescaled_accumulator dut (
        .CLK          (CLK),
        .RST          (RST),
        .En           (En),
        .Div          (Div),
        .Step         (Step),
        .Dir          (Dir),
        .Load         (Load),
        .Load_Value   (Load_Value),
        .Clr_Ovf      (Clr_Ovf),
        .Result       (Result),
        .Tick         (Tick),
        .Overflow     (Overflow),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .Sample_Data  (Sample_Data),
        .Sample_Lost  (Sample_Lost)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing on a falling edge for sampling.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_wrap;
        logic [WIDTH-1:0] exp_borrow;
`ifdef ACC_SAT_EN
        exp_wrap   = 24'hFFFFFF;
        exp_borrow = 24'h000000;
`else
        exp_wrap   = 24'h000001;
        exp_borrow = 24'hFFFFFD;
`endif
        // Reset state
        En = 1'b1;
        cyc(2);
        check_eq("rst_result", Result, 32'd0);
        check_eq("rst_tick", Tick, 32'd0);
        check_eq("rst_valid", Sample_Valid, 32'd0);
        check_eq("rst_ovf", Overflow, 32'd0);
        RST = 1'b0;

        // Basic counting, Div=12
        cyc(12);
        check_eq("pre_tick_result", Result, 32'd0);
        check_eq("pre_tick_tick", Tick, 32'd0);
        cyc(1);
        check_eq("tick1_result", Result, 32'd1);
        check_eq("tick1_tick", Tick, 32'd1);
        check_eq("tick1_valid", Sample_Valid, 32'd1);
        check_eq("tick1_data", Sample_Data, 32'd1);
        cyc(1);
        check_eq("tick1_pulse_end", Tick, 32'd0);
        check_eq("handshake_clear", Sample_Valid, 32'd0);
        cyc(11);
        check_eq("mid_period", Result, 32'd1);
        cyc(1);
        check_eq("tick2_result", Result, 32'd2);
        check_eq("tick2_tick", Tick, 32'd1);
        check_eq("tick2_ovf", Overflow, 32'd0);

        // Carry: load near the top, step 3; Div=0 adopted at this wrap
        Div = 26'd0; Step = 24'd3; Load = 1'b1; Load_Value = 24'hFFFFFE;
        cyc(1);
        Load = 1'b0;
        check_eq("load_result", Result, 32'hFFFFFE);
        check_eq("load_no_tick", Tick, 32'd0);
        cyc(12);
        check_eq("load_hold", Result, 32'hFFFFFE);
        cyc(1);
        En = 1'b0;
        check_eq("carry_result", Result, {8'd0, exp_wrap});
        check_eq("carry_ovf", Overflow, 32'd1);
        Clr_Ovf = 1'b1;
        cyc(1);
        Clr_Ovf = 1'b0;
        check_eq("ovf_cleared", Overflow, 32'd0);

        // Load beats a coincident tick (Div_active=0, En=1)
        En = 1'b1; Load = 1'b1; Load_Value = 24'd2;
        cyc(1);
        Load = 1'b0;
        check_eq("load_prio_result", Result, 32'd2);
        check_eq("load_prio_tick", Tick, 32'd0);
        check_eq("load_prio_ovf", Overflow, 32'd0);

        // Borrow
        Dir = 1'b1; Step = 24'd5;
        cyc(1);
        En = 1'b0;
        check_eq("borrow_result", Result, {8'd0, exp_borrow});
        check_eq("borrow_ovf", Overflow, 32'd1);

        // Borrow coincident with clear keeps Overflow set
        Load = 1'b1;
        cyc(1);
        Load = 1'b0; En = 1'b1; Clr_Ovf = 1'b1;
        cyc(1);
        En = 1'b0;
        check_eq("set_beats_clr", Overflow, 32'd1);
        cyc(1);
        Clr_Ovf = 1'b0;
        check_eq("clr_alone", Overflow, 32'd0);

        // Sample loss with a stalled consumer
        Load = 1'b1; Load_Value = 24'd0; Dir = 1'b0; Step = 24'd1;
        cyc(1);
        Load = 1'b0; Sample_Ready = 1'b0; En = 1'b1;
        cyc(1);
        check_eq("lost_t1_data", Sample_Data, 32'd1);
        check_eq("lost_t1_lost", Sample_Lost, 32'd0);
        cyc(1);
        check_eq("lost_t2_lost", Sample_Lost, 32'd1);
        check_eq("lost_t2_result", Result, 32'd2);
        cyc(1);
        En = 1'b0;
        check_eq("lost_t3_lost", Sample_Lost, 32'd1);
        check_eq("lost_t3_data", Sample_Data, 32'd1);
        cyc(1);
        check_eq("lost_pulse_end", Sample_Lost, 32'd0);
        check_eq("lost_valid_held", Sample_Valid, 32'd1);
        Sample_Ready = 1'b1; En = 1'b1;
        cyc(1);
        En = 1'b0;
        check_eq("capture_consume_data", Sample_Data, 32'd4);
        check_eq("capture_consume_valid", Sample_Valid, 32'd1);
        check_eq("capture_consume_lost", Sample_Lost, 32'd0);
        cyc(1);
        check_eq("drain_valid", Sample_Valid, 32'd0);

        // Divisor change mid-period, then En gap stretching a period
        Div = 26'd12; En = 1'b1;
        cyc(1);
        check_eq("div_reload_result", Result, 32'd5);
        cyc(5);
        Div = 26'd3;
        cyc(7);
        check_eq("old_period_hold", Result, 32'd5);
        cyc(1);
        check_eq("old_period_tick", Result, 32'd6);
        cyc(3);
        check_eq("new_period_hold", Result, 32'd6);
        cyc(1);
        check_eq("new_period_tick", Result, 32'd7);
        cyc(2);
        En = 1'b0;
        cyc(5);
        En = 1'b1;
        cyc(1);
        check_eq("stretch_hold", Result, 32'd7);
        cyc(1);
        check_eq("stretch_tick", Result, 32'd8);
        check_eq("stretch_tick_pulse", Tick, 32'd1);

        // Asynchronous reset with a pending sample and Count=7
        Sample_Ready = 1'b0; Div = 26'd12;
        cyc(4);
        check_eq("pre_rst_valid", Sample_Valid, 32'd1);
        check_eq("pre_rst_result", Result, 32'd9);
        cyc(7);
        RST = 1'b1;
        #1;
        check_eq("async_rst_result", Result, 32'd0);
        check_eq("async_rst_valid", Sample_Valid, 32'd0);
        check_eq("async_rst_data", Sample_Data, 32'd0);
        check_eq("async_rst_lost", Sample_Lost, 32'd0);
        @(negedge CLK);
        RST = 1'b0; Sample_Ready = 1'b1;
        cyc(12);
        check_eq("post_rst_hold", Result, 32'd0);
        cyc(1);
        check_eq("post_rst_tick", Result, 32'd1);
        check_eq("post_rst_pulse", Tick, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prescaled_accumulator
